// File: rtl/bicubic_pkg.sv
// -----------------------------------------------------------------------------
// bicubic_pkg
// Shared definitions for the bicubic weight divider:
//   DW_DEF  - default dividend/quotient width (40-bit bicubic weight product)
//   VW_DEF  - default divisor/remainder width
//   CNT_W   - width of the iteration counter (holds 0..DW)
//   state_e - divider FSM state encoding
// Optional feature macro: BICUBIC_DIV_ROUND_EN adds the ROUND state.
// -----------------------------------------------------------------------------
package bicubic_pkg;

   localparam int DW_DEF = 40;
   localparam int VW_DEF = 20;
   localparam int CNT_W  = 6;

`ifdef BICUBIC_DIV_ROUND_EN
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_e;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DONE  = 2'd3
   } state_e;
`endif

endpackage

// File: rtl/bicubic_div_step.sv
// -----------------------------------------------------------------------------
// bicubic_div_step
// One combinational restoring-division iteration: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor, keep the difference
// when it does not borrow and emit the matching quotient bit.
// Ports:
//   rem_i     - partial remainder before this step (VW+1 bits)
//   msb_i     - next dividend bit, MSB first
//   divisor_i - divisor
//   rem_o     - partial remainder after this step
//   qbit_o    - quotient bit produced by this step
// -----------------------------------------------------------------------------
module bicubic_div_step #(
   parameter int VW = 20
) (
   input  logic [VW:0]   rem_i,
   input  logic          msb_i,
   input  logic [VW-1:0] divisor_i,
   output logic [VW:0]   rem_o,
   output logic          qbit_o
);

   logic [VW:0]   shifted;
   logic [VW+1:0] trial;

   // The remainder entering a step is always below the divisor, so its top
   // bit is zero in normal operation; should it ever be set the shifted value
   // is certainly larger than any divisor and the subtraction must be taken.
   assign shifted = {rem_i[VW-1:0], msb_i};
   assign trial   = {1'b0, shifted} - {2'b00, divisor_i};
   assign qbit_o  = rem_i[VW] | ~trial[VW+1];
   assign rem_o   = qbit_o ? trial[VW:0] : shifted;

endmodule

// File: rtl/bicubic_div.sv
// -----------------------------------------------------------------------------
// bicubic_div
// Multi-cycle unsigned divider for bicubic weight normalisation. Restoring
// division, one quotient bit per clock, with valid/ready handshakes on both
// sides. A zero divisor bypasses the iteration and reports all-ones quotient.
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   in_valid / in_ready  - operand handshake (ready only while idle)
//   dividend, divisor    - unsigned operands, captured on acceptance
//   out_valid / out_ready- result handshake (result held until taken)
//   quotient, remainder  - unsigned results
//   div_by_zero          - set when the captured divisor was zero
// Optional feature macro: BICUBIC_DIV_ROUND_EN rounds the quotient to nearest
// (saturating) in an extra ROUND cycle; remainder stays unrounded.
// -----------------------------------------------------------------------------
module bicubic_div
   import bicubic_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int VW = VW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_by_zero
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DW - 1);

   state_e           state_q, state_d;
   logic [DW-1:0]    quo_q, quo_d;
   logic [VW:0]      rem_q, rem_d;
   logic [VW-1:0]    dvs_q, dvs_d;
   logic             dz_q, dz_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [VW:0]      step_rem;
   logic             step_qbit;

`ifdef BICUBIC_DIV_ROUND_EN
   // Round half up: bump the quotient when 2*remainder >= divisor, never
   // wrapping past all ones.
   function automatic logic [DW-1:0] round_quo(input logic [DW-1:0] q,
                                               input logic [VW:0]   r,
                                               input logic [VW-1:0] d);
      logic [VW+1:0] twice_r;
      twice_r = {r, 1'b0};
      if (twice_r >= {2'b00, d}) begin
         if (&q) return q;
         return q + DW'(1);
      end
      return q;
   endfunction
`endif

   // The quotient register doubles as the dividend shifter: each step takes
   // its MSB into the remainder and shifts the new quotient bit in at the LSB.
   bicubic_div_step #(.VW(VW)) u_step (
      .rem_i     (rem_q),
      .msb_i     (quo_q[DW-1]),
      .divisor_i (dvs_q),
      .rem_o     (step_rem),
      .qbit_o    (step_qbit)
   );

   always_comb begin
      state_d   = state_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dvs_d     = dvs_q;
      dz_d      = dz_q;
      cnt_d     = cnt_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (divisor == '0) begin
                  quo_d   = '1;
                  rem_d   = {1'b0, dividend[VW-1:0]};
                  dz_d    = 1'b1;
                  state_d = DONE;
               end else begin
                  quo_d   = dividend;
                  rem_d   = '0;
                  dvs_d   = divisor;
                  dz_d    = 1'b0;
                  cnt_d   = '0;
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            quo_d = {quo_q[DW-2:0], step_qbit};
            rem_d = step_rem;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) begin
`ifdef BICUBIC_DIV_ROUND_EN
               state_d = ROUND;
`else
               state_d = DONE;
`endif
            end
         end
`ifdef BICUBIC_DIV_ROUND_EN
         ROUND: begin
            quo_d   = round_quo(quo_q, rem_q, dvs_q);
            state_d = DONE;
         end
`endif
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         quo_q   <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         dz_q    <= dz_d;
         cnt_q   <= cnt_d;
      end
   end

   assign quotient    = quo_q;
   assign remainder   = rem_q[VW-1:0];
   assign div_by_zero = dz_q;

endmodule

// File: tb/tb_bicubic_div.sv
// -----------------------------------------------------------------------------
// tb_bicubic_div
// Directed, table-driven bench for bicubic_div with hand-computed results.
// Expectations follow BICUBIC_DIV_ROUND_EN when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_bicubic_div;

   localparam int DW = 40;
   localparam int VW = 20;
`ifdef BICUBIC_DIV_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          div_by_zero;

   int n_chk  = 0;
   int n_fail = 0;

   bicubic_div #(.DW(DW), .VW(VW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] dvd;
      logic [VW-1:0] dvs;
      logic [DW-1:0] q_trunc;
      logic [DW-1:0] q_rnd;
      logic [VW-1:0] rem;
      logic          dz;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Issue one operation, watch its latency (random traffic on the inputs
   // while busy), then hold the result for 'stall' cycles before taking it.
   task automatic run_op(input logic [DW-1:0] dvd, input logic [VW-1:0] dvs,
                         input logic [DW-1:0] eq, input logic [VW-1:0] er,
                         input logic edz, input int elat, input int stall,
                         input string tag);
      int cyc;
      @(negedge clk);
      check({tag, " in_ready before"}, 64'(in_ready), 64'(1));
      dividend = dvd;
      divisor  = dvs;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      dividend = {8'($urandom()), $urandom()};
      divisor  = 20'($urandom());
      cyc = 1;
      while (!out_valid && cyc < 200) begin
         in_valid = (cyc <= 4);
         dividend = {8'($urandom()), $urandom()};
         divisor  = 20'($urandom());
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      if (!out_valid) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s timeout: no out_valid after %0d cycles", tag, cyc);
         return;
      end
      check({tag, " latency"},   64'(cyc),         64'(elat));
      check({tag, " quotient"},  64'(quotient),    64'(eq));
      check({tag, " remainder"}, 64'(remainder),   64'(er));
      check({tag, " dz"},        64'(div_by_zero), 64'(edz));
      check({tag, " in_ready done"}, 64'(in_ready), 64'(0));
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         check({tag, " hold valid"}, 64'(out_valid),   64'(1));
         check({tag, " hold rdy"},   64'(in_ready),    64'(0));
         check({tag, " hold q"},     64'(quotient),    64'(eq));
         check({tag, " hold r"},     64'(remainder),   64'(er));
         check({tag, " hold dz"},    64'(div_by_zero), 64'(edz));
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, " valid drop"}, 64'(out_valid), 64'(0));
      check({tag, " ready back"}, 64'(in_ready),  64'(1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int  lat;
      bit  saw;
      logic [DW-1:0] eq;

      //          dividend            divisor      q (trunc)          q (round)          rem        dz
      vecs[0]  = '{40'd1000,          20'd7,       40'd142,           40'd143,           20'd6,     1'b0};
      vecs[1]  = '{40'hFF_FFFF_FFFF,  20'd1,       40'hFF_FFFF_FFFF,  40'hFF_FFFF_FFFF,  20'd0,     1'b0};
      vecs[2]  = '{40'h12345,         20'd0,       40'hFF_FFFF_FFFF,  40'hFF_FFFF_FFFF,  20'h12345, 1'b1};
      vecs[3]  = '{40'd100,           20'd10,      40'd10,            40'd10,            20'd0,     1'b0};
      vecs[4]  = '{40'hFF_FFFF_FFFF,  20'd2,       40'h7F_FFFF_FFFF,  40'h80_0000_0000,  20'd1,     1'b0};
      vecs[5]  = '{40'd0,             20'd5,       40'd0,             40'd0,             20'd0,     1'b0};
      vecs[6]  = '{40'd12345,         20'd1000,    40'd12,            40'd12,            20'd345,   1'b0};
      vecs[7]  = '{40'hFF_FFFF_FFFF,  20'hFFFFF,   40'h10_0001,       40'h10_0001,       20'd0,     1'b0};
      vecs[8]  = '{40'h123,           20'hFFFFF,   40'd0,             40'd0,             20'h123,   1'b0};
      vecs[9]  = '{40'd15,            20'd4,       40'd3,             40'd4,             20'd3,     1'b0};
      vecs[10] = '{40'hAB_CDEF_1234,  20'd0,       40'hFF_FFFF_FFFF,  40'hFF_FFFF_FFFF,  20'hF1234, 1'b1};
      vecs[11] = '{40'd7,             20'd7,       40'd1,             40'd1,             20'd0,     1'b0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset out_valid", 64'(out_valid),   64'(0));
      check("reset in_ready",  64'(in_ready),    64'(1));
      check("reset quotient",  64'(quotient),    64'(0));
      check("reset remainder", 64'(remainder),   64'(0));
      check("reset dz",        64'(div_by_zero), 64'(0));

      for (int i = 0; i < 12; i++) begin
         lat = vecs[i].dz ? 1 : (DW + 1 + int'(RND));
         eq  = RND ? vecs[i].q_rnd : vecs[i].q_trunc;
         run_op(vecs[i].dvd, vecs[i].dvs, eq, vecs[i].rem, vecs[i].dz, lat, 0,
                $sformatf("vec%0d", i));
      end

      // Result held for five cycles with out_ready low, taken on the sixth.
      run_op(40'd1000, 20'd7, RND ? 40'd143 : 40'd142, 20'd6, 1'b0,
             DW + 1 + int'(RND), 5, "stall");
      run_op(40'h12345, 20'd0, '1, 20'h12345, 1'b1, 1, 5, "stall dz");

      // Reset in the 20th busy cycle: the operation must vanish.
      @(negedge clk);
      dividend = 40'd1000;
      divisor  = 20'd7;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (19) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midreset out_valid", 64'(out_valid), 64'(0));
      check("midreset in_ready",  64'(in_ready),  64'(1));
      check("midreset quotient",  64'(quotient),  64'(0));
      check("midreset remainder", 64'(remainder), 64'(0));
      saw = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (out_valid) saw = 1'b1;
      end
      check("midreset no valid", 64'(saw), 64'(0));
      run_op(40'd100, 20'd10, 40'd10, 20'd0, 1'b0, DW + 1 + int'(RND), 0, "after reset");

      // Reset while a result sits in DONE.
      @(negedge clk);
      dividend = 40'd50;
      divisor  = 20'd0;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("done pre-reset valid", 64'(out_valid), 64'(1));
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("done reset valid", 64'(out_valid),   64'(0));
      check("done reset dz",    64'(div_by_zero), 64'(0));
      check("done reset ready", 64'(in_ready),    64'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/bicubic_div.md
BICUBIC_DIV -- requirements
Module: bicubic_div

Interface
REQ-001 SHALL have parameter DW, default 40, meaning dividend/quotient width matching the 40-bit bicubic weight product.
REQ-002 SHALL have parameter VW, default 20, meaning divisor/remainder width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  dividend/divisor valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a new operation.
REQ-007 SHALL have port dividend  input  DW  unsigned numerator.
REQ-008 SHALL have port divisor  input  VW  unsigned denominator.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port quotient  output  DW  unsigned quotient.
REQ-012 SHALL have port remainder  output  VW  unsigned remainder.
REQ-013 SHALL have port div_by_zero  output  1  flag: divisor was zero.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, ROUND (only when rounding compiled in), DONE.
REQ-015 SHALL assert in_ready only in IDLE; an operation is accepted on a clk edge with in_valid && in_ready.
REQ-016 SHALL register dividend and divisor on acceptance; inputs are ignored at all other times.
REQ-017 SHALL, in BUSY, run restoring division MSB-first, one quotient bit per cycle, for exactly DW cycles, using a 6-bit iteration counter.
REQ-018 SHALL keep the partial remainder VW+1 bits wide so the trial subtraction never overflows.
REQ-019 SHALL move BUSY->DONE after the last iteration, or BUSY->ROUND->DONE when rounding is compiled in.
REQ-020 SHALL assert out_valid in DONE, and hold quotient, remainder and div_by_zero stable until out_valid && out_ready.
REQ-021 SHALL return DONE->IDLE on out_ready; in_ready rises the following cycle, with no same-cycle accept/complete overlap.
REQ-022 SHALL have a latency from the acceptance edge to first out_valid of DW+1 cycles, or DW+2 with rounding.
REQ-023 SHALL, for divisor==0, skip BUSY and go IDLE->DONE next cycle with quotient all ones, remainder=dividend[VW-1:0], and div_by_zero=1.
REQ-024 SHALL drive div_by_zero=0 for every nonzero divisor.

Reset
REQ-025 SHALL, with rst_n low at a clk edge, force IDLE, in_ready=1 after release, out_valid=0, quotient=0, remainder=0, div_by_zero=0, and counter=0.
REQ-026 SHALL, on reset asserted mid-BUSY or in DONE, abandon the operation; no out_valid is produced for it.

Configuration
REQ-027 SHALL provide macro BICUBIC_DIV_ROUND_EN.
REQ-028 SHALL, when it is defined, add the ROUND state: if 2*remainder >= divisor, increment quotient, saturating at all ones; remainder is reported unrounded.
REQ-029 SHALL, when it is undefined, truncate the quotient, exclude the ROUND state, and give latency DW+1.

Structure
REQ-030 SHALL define DW/VW defaults, the FSM state enum typedef and the counter width in shared package bicubic_pkg.
REQ-031 SHALL place one combinational sub-module, bicubic_div_step (shift, trial subtract, select, emit quotient bit), instanced once and reused every cycle.

Verification
REQ-032 SHALL cover: dividend=1000, divisor=7 -> quotient=142, remainder=6 (143 with ROUND_EN), out_valid at cycle 41 (42 with ROUND_EN).
REQ-033 SHALL cover: dividend=40'hFF_FFFF_FFFF, divisor=1 -> quotient=40'hFF_FFFF_FFFF, remainder=0, div_by_zero=0.
REQ-034 SHALL cover: divisor=0, dividend=40'h12345 -> next-cycle out_valid, quotient all ones, remainder=20'h12345, div_by_zero=1.
REQ-035 SHALL cover: out_ready held low 5 cycles in DONE -> outputs stable and in_ready=0 throughout, IDLE on the sixth cycle's ready.
REQ-036 SHALL cover: rst_n low at BUSY cycle 20 -> out_valid never asserts, and a following 100/10 op returns quotient=10, remainder=0.
REQ-037 SHALL cover: dividend=2^40-1, divisor=2 with ROUND_EN -> quotient=2^39, remainder=1.
